// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link: frame FSM states, default link geometry
// and the channel bit-offset helper used by both the mux and the demux.
package tdm_pkg;

  typedef enum logic {HUNT, FILL} state_t;

  localparam int unsigned TDM_NUM_CH = 4;
  localparam int unsigned TDM_DATA_W = 8;

  function automatic int unsigned ch_offset(input int unsigned ch,
                                            input int unsigned data_w);
    return ch * data_w;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demux: restarts at 1 on an accepted start-of-frame
// beat and wraps to 0 after the last channel.
module tdm_slot_ctr #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      restart,
  input  logic                      advance,
  output logic [$clog2(NUM_CH)-1:0] slot,
  output logic                      last
);

  localparam int unsigned SLOT_W = $clog2(NUM_CH);

  assign last = (slot == SLOT_W'(NUM_CH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (restart) begin
      slot <= SLOT_W'(1);
    end else if (advance) begin
      slot <= last ? '0 : slot + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM link receiver: collects one sample per beat into a shadow frame and
// publishes complete frames on a registered valid/ready output.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned NUM_CH = TDM_NUM_CH,
  parameter int unsigned DATA_W = TDM_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_sof,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic                     out_ready,
  output logic                     frame_err
);

  localparam int unsigned SLOT_W = $clog2(NUM_CH);

  state_t                     state;
  logic [SLOT_W-1:0]          slot;
  logic                       last;
  logic                       accept;
  logic                       restart;
  logic                       advance;
  logic                       complete;
  logic [DATA_W-1:0]          shadow [NUM_CH];
  logic [NUM_CH*DATA_W-1:0]   frame_next;

  // Only the last slot can stall: it is the one beat that overwrites out_data.
  always_comb begin
    in_ready = 1'b1;
    if (state == FILL && last) begin
      in_ready = !(out_valid && !out_ready);
    end
  end

  assign accept   = in_valid && in_ready;
  assign restart  = accept && in_sof;
  assign advance  = accept && !in_sof && (state == FILL) && (slot != '0);
  assign complete = advance && last;

  for (genvar k = 0; k < NUM_CH - 1; k++) begin : g_frame
    assign frame_next[ch_offset(k, DATA_W) +: DATA_W] = shadow[k];
  end
  assign frame_next[ch_offset(NUM_CH - 1, DATA_W) +: DATA_W] = in_data;

  tdm_slot_ctr #(
    .NUM_CH (NUM_CH)
  ) u_slot_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .advance (advance),
    .slot    (slot),
    .last    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      out_valid <= 1'b0;
      out_data  <= '0;
      frame_err <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        shadow[k] <= '0;
      end
    end else begin
      frame_err <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (complete) begin
        out_valid <= 1'b1;
        out_data  <= frame_next;
      end
      if (accept) begin
        if (in_sof) begin
          shadow[0] <= in_data;
          state     <= FILL;
          if (state == FILL && slot != '0) begin
            frame_err <= 1'b1;
          end
        end else if (state == FILL) begin
          if (slot == '0) begin
            frame_err <= 1'b1;
            state     <= HUNT;
          end else if (!last) begin
            shadow[slot] <= in_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: a frame-level reference model predicts
// frames and framing errors; a monitor checks them as the DUT presents them.
module tb_tdm_demux;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 8;

  typedef struct {
    logic [NUM_CH*DATA_W-1:0] data;
    int                       due;
  } frm_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic                     in_sof;
  logic                     in_ready;
  logic                     out_valid;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic                     out_ready;
  logic                     frame_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rnd_mode = 1'b0;

  bit                hunting;
  logic [DATA_W-1:0] partial [$];
  frm_t              exp_q [$];
  int                err_q [$];

  tdm_demux #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Frame-level model: a frame is a sof beat followed by NUM_CH-1 plain beats.
  task automatic model_accept(input bit sof, input logic [DATA_W-1:0] d);
    logic [NUM_CH*DATA_W-1:0] f;
    if (hunting) begin
      if (sof) begin
        partial = {d};
        hunting = 1'b0;
      end
    end else if (sof) begin
      if (partial.size() != 0) err_q.push_back(cyc + 1);
      partial = {d};
    end else if (partial.size() == 0) begin
      err_q.push_back(cyc + 1);
      hunting = 1'b1;
    end else begin
      partial.push_back(d);
      if (partial.size() == NUM_CH) begin
        f = '0;
        for (int k = 0; k < NUM_CH; k++) f[k*DATA_W +: DATA_W] = partial[k];
        exp_q.push_back('{data: f, due: cyc + 1});
        partial.delete();
      end
    end
  endtask

  task automatic model_reset();
    hunting = 1'b1;
    partial.delete();
    exp_q.delete();
    err_q.delete();
  endtask

  // Called at a falling edge; returns at a later falling edge.
  task automatic beat(input bit sof, input logic [DATA_W-1:0] d);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    for (int i = 0; i < 64 && !done; i++) begin
      if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
      #3;
      if (in_ready) begin
        model_accept(sof, d);
        done = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) fail_now("beat_accept_timeout");
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
  endtask

  task automatic frame4(input logic [DATA_W-1:0] a, b, c, d);
    beat(1'b1, a);
    beat(1'b0, b);
    beat(1'b0, c);
    beat(1'b0, d);
  endtask

  // Monitor: samples between the falling edge and the next rising edge.
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst_n) continue;
    if (frame_err) begin
      if (err_q.size() == 0) fail_now("spurious_frame_err");
      else chk("frame_err_cycle", 64'(cyc), 64'(err_q.pop_front()));
    end else if (err_q.size() != 0 && err_q[0] <= cyc) begin
      void'(err_q.pop_front());
      fail_now("missed_frame_err");
    end
    if (out_valid) begin
      if (exp_q.size() == 0) fail_now("spurious_out_valid");
      else begin
        chk("frame_data", 64'(out_data), 64'(exp_q[0].data));
        if (out_ready) void'(exp_q.pop_front());
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      void'(exp_q.pop_front());
      fail_now("frame_late");
    end
  end

  initial begin
    int pos;
    bit sof;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    model_reset();
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // nominal
    frame4(8'h11, 8'h22, 8'h33, 8'h44);
    idle(3);
    // hunt: plain beats before the first sof are dropped
    beat(1'b0, 8'hAA);
    beat(1'b0, 8'hBB);
    frame4(8'h01, 8'h02, 8'h03, 8'h04);
    idle(3);
    // early sof restarts the frame
    beat(1'b1, 8'h10);
    beat(1'b0, 8'h20);
    frame4(8'h30, 8'h40, 8'h50, 8'h60);
    idle(3);
    // missing sof after a complete, held frame
    out_ready = 1'b0;
    frame4(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    beat(1'b0, 8'h77);
    idle(3);
    out_ready = 1'b1;
    idle(2);

    // backpressure: stall only on the last slot, then swap frames in one edge
    out_ready = 1'b0;
    frame4(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_sof   = (i == 0);
      in_data  = 8'(8'hB1 + i);
      #3;
      chk("bp_ready_early_slot", 64'(in_ready), 64'd1);
      if (in_ready) model_accept(in_sof, in_data);
      @(negedge clk);
    end
    in_sof  = 1'b0;
    in_data = 8'hB4;
    repeat (3) begin
      #3;
      chk("bp_ready_last_slot", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #3;
    chk("bp_ready_released", 64'(in_ready), 64'd1);
    if (in_ready) model_accept(1'b0, 8'hB4);
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    chk("bp_back_to_back_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    idle(3);

    // reset mid-frame with a held frame pending
    out_ready = 1'b0;
    frame4(8'hD1, 8'hD2, 8'hD3, 8'hD4);
    beat(1'b1, 8'hE1);
    beat(1'b0, 8'hE2);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    beat(1'b0, 8'hE3);
    frame4(8'hF1, 8'hF2, 8'hF3, 8'hF4);
    idle(3);

    // randomized traffic with occasional framing faults and idles
    rnd_mode = 1'b1;
    pos = 0;
    repeat (600) begin
      sof = (pos == 0);
      if ($urandom_range(0, 9) == 0) sof = !sof;
      beat(sof, 8'($urandom));
      pos = sof ? 1 : (pos + 1) % NUM_CH;
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    rnd_mode  = 1'b0;
    out_ready = 1'b1;
    idle(10);
    chk("frames_drained", 64'(exp_q.size()), 64'd0);
    chk("errors_drained", 64'(err_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
